// File: rtl/m64_pkg.sv
// Shared widths, partial-product slice offsets and the golden reference sum
// for the 64x64 multiplier's partial-product combiner.
package m64_pkg;

    localparam int PP_W   = 64;
    localparam int PPS_W  = 256;
    localparam int PROD_W = 128;

    localparam int LL_LSB = 0;
    localparam int LH_LSB = 64;
    localparam int HL_LSB = 128;
    localparam int HH_LSB = 192;

    // Straight 128-bit sum HH<<64 + (LH+HL)<<32 + LL, wrapping modulo 2^128.
    function automatic logic [PROD_W-1:0] pp_ref(input logic [PPS_W-1:0] pps);
        logic [PROD_W-1:0] ll;
        logic [PROD_W-1:0] lh;
        logic [PROD_W-1:0] hl;
        logic [PROD_W-1:0] hh;
        ll = {64'b0, pps[LL_LSB +: PP_W]};
        lh = {64'b0, pps[LH_LSB +: PP_W]};
        hl = {64'b0, pps[HL_LSB +: PP_W]};
        hh = {64'b0, pps[HH_LSB +: PP_W]};
        return (hh << 64) + (lh << 32) + (hl << 32) + ll;
    endfunction

endpackage

// File: rtl/m64_pipe_reg.sv
// One valid/ready register slice; accepts whenever empty or draining,
// so a full chain of these sustains one transfer per cycle.
module m64_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/m64_pp_combine.sv
// Two-stage reduction of four 32x32-derived partial products to the 128-bit
// product, with a pass-through tag and valid/ready on both sides.
module m64_pp_combine
    import m64_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pp_valid,
    output logic              pp_ready,
    input  logic [PPS_W-1:0]  pp_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              p_valid,
    input  logic              p_ready,
    output logic [PROD_W-1:0] p_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [1:0]        inflight
);

    // Stage-1 word layout: {tag, hh[63:0], mid_hi[32:0], c, lo[63:0]}
    localparam int S1_LO  = 0;
    localparam int S1_C   = 64;
    localparam int S1_MID = 65;
    localparam int S1_HH  = 98;
    localparam int S1_TAG = 162;
    localparam int S1_W   = S1_TAG + TAG_W;
    localparam int S2_W   = PROD_W + TAG_W;

    logic [PP_W-1:0]   w_ll;
    logic [PP_W-1:0]   w_lh;
    logic [PP_W-1:0]   w_hl;
    logic [PP_W-1:0]   w_hh;
    logic [PP_W:0]     w_mid;
    logic [PP_W:0]     w_lo;
    logic [S1_W-1:0]   w_s1_in;
    logic [S1_W-1:0]   w_s1_out;
    logic              w_s1_valid;
    logic              w_s2_ready;
    logic [PP_W-1:0]   w_hi;
    logic [S2_W-1:0]   w_s2_in;
    logic [S2_W-1:0]   w_s2_out;

    assign w_ll = pp_i[LL_LSB +: PP_W];
    assign w_lh = pp_i[LH_LSB +: PP_W];
    assign w_hl = pp_i[HL_LSB +: PP_W];
    assign w_hh = pp_i[HH_LSB +: PP_W];

    assign w_mid   = {1'b0, w_lh} + {1'b0, w_hl};
    assign w_lo    = {1'b0, w_ll} + {1'b0, w_mid[31:0], 32'b0};
    assign w_s1_in = {tag_i, w_hh, w_mid[64:32], w_lo[64], w_lo[63:0]};

    m64_pipe_reg #(.W(S1_W)) u_stage1 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (pp_valid),
        .o_ready (pp_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_out)
    );

    // Upper half folds the stage-1 low-half carry in with the mid overflow.
    assign w_hi = w_s1_out[S1_HH +: PP_W]
                + {31'b0, w_s1_out[S1_MID +: 33]}
                + {63'b0, w_s1_out[S1_C]};
    assign w_s2_in = {w_s1_out[S1_TAG +: TAG_W], w_hi, w_s1_out[S1_LO +: PP_W]};

    m64_pipe_reg #(.W(S2_W)) u_stage2 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (p_valid),
        .i_ready (p_ready),
        .o_data  (w_s2_out)
    );

    assign p_o      = w_s2_out[PROD_W-1:0];
    assign tag_o    = w_s2_out[S2_W-1 -: TAG_W];
    assign inflight = {1'b0, w_s1_valid} + {1'b0, p_valid};

endmodule

// File: tb/tb_m64_pp_combine.sv
// Directed bench for m64_pp_combine: corner products, streaming, stall and reset.
module tb_m64_pp_combine;
    import m64_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              pp_valid;
    logic              pp_ready;
    logic [PPS_W-1:0]  pp_i;
    logic [7:0]        tag_i;
    logic              p_valid;
    logic              p_ready;
    logic [PROD_W-1:0] p_o;
    logic [7:0]        tag_o;
    logic [1:0]        inflight;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [PPS_W-1:0] pps [16];
    logic [PPS_W-1:0] bp  [3];
    logic [PP_W-1:0]  max_pp;

    m64_pp_combine #(.TAG_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .pp_valid (pp_valid),
        .pp_ready (pp_ready),
        .pp_i     (pp_i),
        .tag_i    (tag_i),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .p_o      (p_o),
        .tag_o    (tag_o),
        .inflight (inflight)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Single set through an otherwise idle pipeline with p_ready held high.
    task automatic send_one(input string name, input logic [PPS_W-1:0] pp,
                            input logic [7:0] tg, input logic [127:0] exp);
        pp_valid = 1'b1;
        pp_i     = pp;
        tag_i    = tg;
        chk({name, "_ready"}, 128'(pp_ready), 128'd1);
        tick();
        pp_valid = 1'b0;
        chk({name, "_s1_only"}, 128'(p_valid), 128'd0);
        chk({name, "_infl1"}, 128'(inflight), 128'd1);
        tick();
        chk({name, "_valid"}, 128'(p_valid), 128'd1);
        chk({name, "_p"}, p_o, exp);
        chk({name, "_tag"}, 128'(tag_o), 128'(tg));
        tick();
        chk({name, "_drained"}, 128'(inflight), 128'd0);
    endtask

    initial begin
        reset    = 1'b1;
        pp_valid = 1'b0;
        pp_i     = '0;
        tag_i    = '0;
        p_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pvalid", 128'(p_valid), 128'd0);
        chk("rst_inflight", 128'(inflight), 128'd0);
        chk("rst_ppready", 128'(pp_ready), 128'd1);
        chk("rst_p", p_o, 128'd0);
        chk("rst_tag", 128'(tag_o), 128'd0);

        max_pp = 64'hFFFFFFFE_00000001;
        send_one("max", {max_pp, max_pp, max_pp, max_pp}, 8'hA5,
                 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
        send_one("carry", {64'd0, 64'd0, 64'h1_00000000, 64'hFFFFFFFF_FFFFFFFF}, 8'h3C,
                 128'h1_FFFFFFFF_FFFFFFFF);
        send_one("zero", '0, 8'h00, 128'd0);
        send_one("ident", {64'd0, 64'd0, 64'd0, 64'd7}, 8'h77, 128'd7);

        // Streaming: output after edge i carries set i-1.
        for (int i = 0; i < 16; i++) begin
            pps[i] = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        end
        p_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            pp_valid = (i < 16);
            pp_i     = (i < 16) ? pps[i] : '0;
            tag_i    = 8'(i);
            if (i < 16) chk($sformatf("stream_ready%0d", i), 128'(pp_ready), 128'd1);
            tick();
            if (i >= 1) begin
                chk($sformatf("stream_valid%0d", i - 1), 128'(p_valid), 128'd1);
                chk($sformatf("stream_p%0d", i - 1), p_o, pp_ref(pps[i - 1]));
                chk($sformatf("stream_tag%0d", i - 1), 128'(tag_o), 128'(i - 1));
            end
        end
        pp_valid = 1'b0;
        tick();
        chk("stream_drained", 128'(inflight), 128'd0);

        // Backpressure: three sets offered while the sink stalls.
        bp[0] = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'hDEADBEEFCAFEF00D};
        bp[1] = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
        bp[2] = {64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000100000000};
        p_ready  = 1'b0;
        pp_valid = 1'b1;
        pp_i     = bp[0];
        tag_i    = 8'h20;
        chk("bp_ready0", 128'(pp_ready), 128'd1);
        tick();
        pp_i  = bp[1];
        tag_i = 8'h21;
        chk("bp_ready1", 128'(pp_ready), 128'd1);
        tick();
        pp_i  = bp[2];
        tag_i = 8'h22;
        chk("bp_ready_low", 128'(pp_ready), 128'd0);
        chk("bp_inflight", 128'(inflight), 128'd2);
        chk("bp_p_hold0", p_o, pp_ref(bp[0]));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_stall_ready%0d", k), 128'(pp_ready), 128'd0);
            chk($sformatf("bp_stall_p%0d", k), p_o, pp_ref(bp[0]));
            chk($sformatf("bp_stall_tag%0d", k), 128'(tag_o), 128'h20);
            chk($sformatf("bp_stall_valid%0d", k), 128'(p_valid), 128'd1);
        end
        p_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(pp_ready), 128'd1);
        tick();
        pp_valid = 1'b0;
        chk("bp_out1_p", p_o, pp_ref(bp[1]));
        chk("bp_out1_tag", 128'(tag_o), 128'h21);
        tick();
        chk("bp_out2_p", p_o, pp_ref(bp[2]));
        chk("bp_out2_tag", 128'(tag_o), 128'h22);
        chk("bp_out2_valid", 128'(p_valid), 128'd1);
        tick();
        chk("bp_done_valid", 128'(p_valid), 128'd0);
        chk("bp_done_inflight", 128'(inflight), 128'd0);

        // Reset with two products in flight.
        p_ready  = 1'b0;
        pp_valid = 1'b1;
        pp_i     = bp[1];
        tag_i    = 8'h40;
        tick();
        tag_i = 8'h41;
        tick();
        pp_valid = 1'b0;
        chk("mrst_pre_inflight", 128'(inflight), 128'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_pvalid", 128'(p_valid), 128'd0);
        chk("mrst_inflight", 128'(inflight), 128'd0);
        chk("mrst_ppready", 128'(pp_ready), 128'd1);
        chk("mrst_p", p_o, 128'd0);
        p_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mrst_quiet%0d", k), 128'(p_valid), 128'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
